matrix_row_scale_pipe: RTL and testbench

- Pipelined, parametrised row-scaling unit for the MHA datapath. Each cycle it accepts one matrix row of COLS signed fixed-point lanes plus one per-row signed scale. It outputs the row multiplied element-wise by that scale.
- Replaces the flat combinational 16x16 matrix-by-vector-per-row scaler with a streaming block:
  - valid/ready handshake
  - saturating Q-format arithmetic
  - row counting with end-of-matrix framing
- Sits between the score/softmax stage and the downstream matmul, so a matrix can be scaled row-by-row without a full 2-D port.

---
 rtl/matrix_row_scale_pipe_if.sv | 32 +++
 rtl/matrix_row_scale_pipe.sv | 142 ++++++++++++++
 tb/tb_matrix_row_scale_pipe.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_row_scale_pipe_if.sv
// Row stream bundle for matrix_row_scale_pipe: input row, scaled output row.
// master = producer/consumer side, slave = the scaler.
interface matrix_row_scale_pipe_if #(
  parameter int DW   = 16,
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int IW   = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic               I_VALID;
  logic               O_READY;
  logic [COLS*DW-1:0] I_ROW;
  logic [DW-1:0]      I_SCALE;
  logic               O_VALID;
  logic               I_READY;
  logic [COLS*DW-1:0] O_ROW;
  logic [IW-1:0]      O_ROW_IDX;
  logic               O_LAST;
  logic               O_SAT;
  logic               O_BUSY;

  modport master (
    output I_VALID, I_ROW, I_SCALE, I_READY,
    input  O_READY, O_VALID, O_ROW, O_ROW_IDX,
    input  O_LAST, O_SAT, O_BUSY
  );

  modport slave (
    input  I_VALID, I_ROW, I_SCALE, I_READY,
    output O_READY, O_VALID, O_ROW, O_ROW_IDX,
    output O_LAST, O_SAT, O_BUSY
  );
endinterface

// File: rtl/matrix_row_scale_pipe.sv
// Two-stage streaming row scaler with saturating Q-format multiply.
// Define MATRIX_ROW_SCALE_ROUND_EN for round-half-up instead of floor.
module matrix_row_scale_pipe #(
  parameter int DW   = 16,
  parameter int FRAC = 13,
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic I_CLK,
  input  logic I_RST_N,
  input  logic I_CLR,
  matrix_row_scale_pipe_if.slave bus
);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = 2 * DW;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);
  localparam logic signed [PW:0] MAXV =
    {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(DW + 2){1'b1}}, {(DW - 1){1'b0}}};
`ifdef MATRIX_ROW_SCALE_ROUND_EN
  localparam logic signed [PW:0] RND =
    {{(PW + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state, state_nxt;
  logic [IW-1:0] cnt;
  logic s1_v, s2_v, s1_adv, s2_adv;
  logic accept, consume;
  logic signed [PW-1:0] prod [COLS];
  logic signed [PW-1:0] s1_prod [COLS];
  logic signed [PW:0] wide [COLS];
  logic [IW-1:0] s1_idx;
  logic [COLS*DW-1:0] res;
  logic [COLS-1:0] sat_lane;
  logic [COLS*DW-1:0] s2_row;
  logic [IW-1:0] s2_idx;
  logic s2_last, s2_sat;

  // A stage may load when it is empty or its contents move on.
  assign s2_adv  = !s2_v || bus.I_READY;
  assign s1_adv  = !s1_v || s2_adv;
  assign accept  = bus.I_VALID && bus.O_READY && !I_CLR;
  assign consume = s2_v && bus.I_READY && !I_CLR;

  assign bus.O_READY   = I_RST_N && (state != DRAIN) && s1_adv;
  assign bus.O_VALID   = s2_v;
  assign bus.O_ROW     = s2_row;
  assign bus.O_ROW_IDX = s2_idx;
  assign bus.O_LAST    = s2_last;
  assign bus.O_SAT     = s2_sat;
  assign bus.O_BUSY    = (state != IDLE);

  always_comb begin
    for (int k = 0; k < COLS; k++) begin
      prod[k] =
        $signed({{DW{bus.I_ROW[k*DW+DW-1]}}, bus.I_ROW[k*DW +: DW]}) *
        $signed({{DW{bus.I_SCALE[DW-1]}}, bus.I_SCALE});
    end
  end

  always_comb begin
    res      = '0;
    sat_lane = '0;
    for (int k = 0; k < COLS; k++) begin
`ifdef MATRIX_ROW_SCALE_ROUND_EN
      wide[k] = ($signed({s1_prod[k][PW-1], s1_prod[k]}) + RND) >>> FRAC;
`else
      wide[k] = $signed({s1_prod[k][PW-1], s1_prod[k]}) >>> FRAC;
`endif
      if (wide[k] > MAXV) begin
        res[k*DW +: DW] = MAXV[DW-1:0];
        sat_lane[k]     = 1'b1;
      end else if (wide[k] < MINV) begin
        res[k*DW +: DW] = MINV[DW-1:0];
        sat_lane[k]     = 1'b1;
      end else begin
        res[k*DW +: DW] = wide[k][DW-1:0];
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      s1_v   <= 1'b0;
      s1_idx <= '0;
      for (int k = 0; k < COLS; k++) s1_prod[k] <= '0;
    end else if (I_CLR) begin
      s1_v <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= accept;
      if (accept) begin
        s1_idx <= cnt;
        for (int k = 0; k < COLS; k++) s1_prod[k] <= prod[k];
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      s2_v    <= 1'b0;
      s2_row  <= '0;
      s2_idx  <= '0;
      s2_last <= 1'b0;
      s2_sat  <= 1'b0;
    end else if (I_CLR) begin
      s2_v <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_row  <= res;
        s2_idx  <= s1_idx;
        s2_last <= (s1_idx == LAST_IDX);
        s2_sat  <= |sat_lane;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (I_CLR) cnt <= '0;
      else if (accept) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (cnt == LAST_IDX) ? DRAIN : FILL;
      FILL:    if (accept && cnt == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (consume && s2_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (I_CLR) state_nxt = IDLE;
  end
endmodule

// File: tb/tb_matrix_row_scale_pipe.sv
// Bench for matrix_row_scale_pipe: directed vectors plus a random
// stream checked against an arithmetic reference model.
module tb_matrix_row_scale_pipe;
  localparam int DW   = 16;
  localparam int FRAC = 13;
  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam int IW   = 4;

  typedef struct {
    logic [COLS*DW-1:0] row;
    logic [IW-1:0]      idx;
    logic               last;
    logic               sat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;
  int errors = 0;
  int checks = 0;

  matrix_row_scale_pipe_if #(.DW(DW), .COLS(COLS), .ROWS(ROWS)) bus ();

  matrix_row_scale_pipe #(
    .DW(DW), .FRAC(FRAC), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .I_CLK(clk),
    .I_RST_N(rst_n),
    .I_CLR(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void ref_row(
    input  logic [COLS*DW-1:0] row,
    input  logic [DW-1:0]      sc,
    output logic [COLS*DW-1:0] o,
    output logic               sat
  );
    longint p, q, d, hi, lo;
    logic [DW-1:0] a;
    d  = longint'(1) << FRAC;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    o   = '0;
    sat = 1'b0;
    for (int k = 0; k < COLS; k++) begin
      a = row[k*DW +: DW];
      p = longint'($signed(a)) * longint'($signed(sc));
`ifdef MATRIX_ROW_SCALE_ROUND_EN
      p = p + d / 2;
`endif
      q = p / d;
      if ((p % d) != 0 && p < 0) q = q - 1;
      if (q > hi) begin
        q = hi; sat = 1'b1;
      end else if (q < lo) begin
        q = lo; sat = 1'b1;
      end
      o[k*DW +: DW] = q[DW-1:0];
    end
  endfunction

  function automatic logic [COLS*DW-1:0] rand_row();
    logic [COLS*DW-1:0] r;
    for (int k = 0; k < COLS; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_scale();
    if ($urandom_range(0, 1) == 0) return DW'($urandom);
    return DW'($urandom_range(0, 16383) - 8192);
  endfunction

  function automatic exp_t make_exp(
    input logic [COLS*DW-1:0] row, input logic [DW-1:0] sc, input int n
  );
    exp_t e;
    ref_row(row, sc, e.row, e.sat);
    e.idx  = IW'(n % ROWS);
    e.last = ((n % ROWS) == ROWS - 1);
    return e;
  endfunction

  task automatic pulse_clr;
    @(negedge clk);
    clr = 1'b1;
    bus.I_VALID = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic one_row(
    input  logic [COLS*DW-1:0] row,
    input  logic [DW-1:0]      sc,
    output logic v1, output logic v2,
    output logic [COLS*DW-1:0] o,
    output logic [IW-1:0] idx,
    output logic last, output logic sat
  );
    @(negedge clk);
    bus.I_VALID = 1'b1;
    bus.I_ROW   = row;
    bus.I_SCALE = sc;
    bus.I_READY = 1'b1;
    @(negedge clk);
    bus.I_VALID = 1'b0;
    v1 = bus.O_VALID;
    @(negedge clk);
    v2   = bus.O_VALID;
    o    = bus.O_ROW;
    idx  = bus.O_ROW_IDX;
    last = bus.O_LAST;
    sat  = bus.O_SAT;
  endtask

  task automatic fill_and_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.I_VALID = 1'b1;
      bus.I_READY = 1'b1;
      bus.I_ROW   = {COLS{16'h1000}};
      bus.I_SCALE = 16'h2000;
    end
    @(negedge clk);
    bus.I_VALID = 1'b0;
    bus.I_READY = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #10;
    checks++;
    if (bus.O_READY !== 1'b0 || bus.O_VALID !== 1'b0 ||
        bus.O_BUSY !== 1'b0 || bus.O_ROW !== '0 ||
        bus.O_ROW_IDX !== '0 || bus.O_LAST !== 1'b0 ||
        bus.O_SAT !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b idx=%0d last=%b sat=%b row=%h, required all 0",
               bus.O_READY, bus.O_VALID, bus.O_BUSY, bus.O_ROW_IDX,
               bus.O_LAST, bus.O_SAT, bus.O_ROW);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.O_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", bus.O_READY);
    end
  endtask

  task automatic test_unity;
    logic v1, v2, last, sat;
    logic [COLS*DW-1:0] o;
    logic [IW-1:0] idx;
    pulse_clr;
    one_row({COLS{16'h2000}}, 16'h2000, v1, v2, o, idx, last, sat);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      errors++;
      $display("FAIL unity_latency: valid@1=%b valid@2=%b required 0,1", v1, v2);
    end
    checks++;
    if (o !== {COLS{16'h2000}} || idx !== 4'd0 || sat !== 1'b0 || last !== 1'b0) begin
      errors++;
      $display("FAIL unity_data: row=%h idx=%0d sat=%b last=%b required all 2000 idx 0 sat 0 last 0",
               o, idx, sat, last);
    end
  endtask

  task automatic test_saturation;
    logic v1, v2, last, sat;
    logic [COLS*DW-1:0] o, row, want;
    logic [IW-1:0] idx;
    pulse_clr;
    row = '0;
    row[15:0]  = 16'h4000;
    row[31:16] = 16'hC000;
    want = '0;
    want[15:0]  = 16'h7FFF;
    want[31:16] = 16'h8000;
    one_row(row, 16'h4000, v1, v2, o, idx, last, sat);
    checks++;
    if (v2 !== 1'b1 || o !== want || sat !== 1'b1 || idx !== 4'd0) begin
      errors++;
      $display("FAIL sat_clip: valid=%b row=%h sat=%b idx=%0d required row=%h sat=1 idx 0",
               v2, o, sat, idx, want);
    end
    one_row({COLS{16'hE000}}, 16'h2000, v1, v2, o, idx, last, sat);
    checks++;
    if (v2 !== 1'b1 || o !== {COLS{16'hE000}} || sat !== 1'b0 || idx !== 4'd1) begin
      errors++;
      $display("FAIL sat_negative_inrange: valid=%b row=%h sat=%b idx=%0d required all E000 sat 0 idx 1",
               v2, o, sat, idx);
    end
  endtask

  task automatic test_rounding;
    logic v1, v2, last, sat;
    logic [COLS*DW-1:0] o, row, want1, want2;
    logic [IW-1:0] idx;
    row = '0;
    row[15:0] = 16'h0001;
    want1 = '0;
`ifdef MATRIX_ROW_SCALE_ROUND_EN
    want1[15:0] = 16'h0001;
    want2 = '0;
`else
    want2 = {COLS{16'hFFFF}};
`endif
    pulse_clr;
    one_row(row, 16'h1000, v1, v2, o, idx, last, sat);
    checks++;
    if (v2 !== 1'b1 || o !== want1 || sat !== 1'b0) begin
      errors++;
      $display("FAIL round_half: valid=%b row=%h sat=%b required row=%h sat 0", v2, o, sat, want1);
    end
    one_row({COLS{16'hFFFF}}, 16'h0001, v1, v2, o, idx, last, sat);
    checks++;
    if (v2 !== 1'b1 || o !== want2 || sat !== 1'b0) begin
      errors++;
      $display("FAIL round_neg_tiny: valid=%b row=%h sat=%b required row=%h sat 0", v2, o, sat, want2);
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e, hold;
    logic [COLS*DW-1:0] rows [ROWS];
    logic [DW-1:0] scales [ROWS];
    logic rdy, prev_stall;
    int sent, got;
    for (int i = 0; i < ROWS; i++) begin
      rows[i]   = rand_row();
      scales[i] = rand_scale();
    end
    pulse_clr;
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 2000 && got < ROWS; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (bus.O_VALID !== 1'b1 || bus.O_ROW !== hold.row ||
            bus.O_ROW_IDX !== hold.idx || bus.O_LAST !== hold.last ||
            bus.O_SAT !== hold.sat) begin
          errors++;
          $display("FAIL b2b_hold: valid=%b idx=%0d row=%h required held idx=%0d row=%h",
                   bus.O_VALID, bus.O_ROW_IDX, bus.O_ROW, hold.idx, hold.row);
        end
      end
      rdy = ($urandom_range(0, 2) != 0);
      bus.I_READY = rdy;
      if (sent < ROWS) begin
        bus.I_VALID = 1'b1;
        bus.I_ROW   = rows[sent];
        bus.I_SCALE = scales[sent];
      end else begin
        bus.I_VALID = 1'b0;
      end
      #1;
      if (bus.O_VALID && rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_row: idx=%0d required no row", bus.O_ROW_IDX);
        end else begin
          e = q.pop_front();
          if (bus.O_ROW !== e.row || bus.O_ROW_IDX !== e.idx ||
              bus.O_LAST !== e.last || bus.O_SAT !== e.sat) begin
            errors++;
            $display("FAIL b2b_row: idx=%0d last=%b sat=%b row=%h required idx=%0d last=%b sat=%b row=%h",
                     bus.O_ROW_IDX, bus.O_LAST, bus.O_SAT, bus.O_ROW,
                     e.idx, e.last, e.sat, e.row);
          end
        end
        got++;
      end
      prev_stall = bus.O_VALID && !rdy;
      if (prev_stall) begin
        hold.row  = bus.O_ROW;
        hold.idx  = bus.O_ROW_IDX;
        hold.last = bus.O_LAST;
        hold.sat  = bus.O_SAT;
      end
      if (bus.I_VALID && bus.O_READY) begin
        q.push_back(make_exp(rows[sent], scales[sent], sent));
        sent++;
      end
    end
    bus.I_VALID = 1'b0;
    checks++;
    if (got != ROWS) begin
      errors++;
      $display("FAIL b2b_timeout: delivered %0d rows required %0d", got, ROWS);
    end
  endtask

  task automatic test_drain_block;
    exp_t q[$];
    exp_t e;
    logic [COLS*DW-1:0] r;
    logic [DW-1:0] s;
    int sent, got, phase;
    pulse_clr;
    sent = 0;
    got = 0;
    phase = 0;
    r = rand_row();
    s = rand_scale();
    for (int cyc = 0; cyc < 200 && got <= ROWS; cyc++) begin
      @(negedge clk);
      if (phase == 1) begin
        checks++;
        if (bus.O_BUSY !== 1'b1) begin
          errors++;
          $display("FAIL drain_busy_resume: got %b required 1", bus.O_BUSY);
        end
        phase = 2;
      end
      bus.I_READY = 1'b1;
      bus.I_VALID = 1'b1;
      bus.I_ROW   = r;
      bus.I_SCALE = s;
      #1;
      if (sent == ROWS && got < ROWS) begin
        checks++;
        if (bus.O_READY !== 1'b0) begin
          errors++;
          $display("FAIL drain_ready: got %b required 0 (consumed %0d)", bus.O_READY, got);
        end
      end
      if (got == ROWS && phase == 0) begin
        checks++;
        if (bus.O_BUSY !== 1'b0 || bus.O_READY !== 1'b1) begin
          errors++;
          $display("FAIL drain_gap: busy=%b ready=%b required busy 0 ready 1",
                   bus.O_BUSY, bus.O_READY);
        end
        phase = 1;
      end
      if (bus.O_VALID) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL drain_extra_row: idx=%0d required no row", bus.O_ROW_IDX);
        end else begin
          e = q.pop_front();
          if (bus.O_ROW !== e.row || bus.O_ROW_IDX !== e.idx ||
              bus.O_LAST !== e.last || bus.O_SAT !== e.sat) begin
            errors++;
            $display("FAIL drain_row: idx=%0d last=%b row=%h required idx=%0d last=%b row=%h",
                     bus.O_ROW_IDX, bus.O_LAST, bus.O_ROW, e.idx, e.last, e.row);
          end
        end
        got++;
      end
      if (bus.O_READY) begin
        q.push_back(make_exp(r, s, sent));
        sent++;
        r = rand_row();
        s = rand_scale();
      end
    end
    bus.I_VALID = 1'b0;
    checks++;
    if (got != ROWS + 1 || phase != 2) begin
      errors++;
      $display("FAIL drain_timeout: delivered %0d phase %0d required %0d and 2",
               got, phase, ROWS + 1);
    end
  endtask

  task automatic test_clear;
    logic v1, v2, last, sat;
    logic [COLS*DW-1:0] o;
    logic [IW-1:0] idx;
    pulse_clr;
    fill_and_stall;
    checks++;
    if (bus.O_VALID !== 1'b1) begin
      errors++;
      $display("FAIL clr_stalled: valid=%b required 1", bus.O_VALID);
    end
    clr = 1'b1;
    bus.I_VALID = 1'b1;
    bus.I_READY = 1'b1;
    bus.I_ROW   = {COLS{16'h0800}};
    bus.I_SCALE = 16'h2000;
    @(negedge clk);
    clr = 1'b0;
    bus.I_VALID = 1'b0;
    #1;
    checks++;
    if (bus.O_VALID !== 1'b0 || bus.O_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL clr_flush: valid=%b busy=%b required 0,0", bus.O_VALID, bus.O_BUSY);
    end
    one_row({COLS{16'h2000}}, 16'h2000, v1, v2, o, idx, last, sat);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1 || idx !== 4'd0 || o !== {COLS{16'h2000}}) begin
      errors++;
      $display("FAIL clr_restart: v1=%b v2=%b idx=%0d row=%h required 0,1 idx 0 all 2000",
               v1, v2, idx, o);
    end
  endtask

  task automatic test_async_reset;
    logic v1, v2, last, sat;
    logic [COLS*DW-1:0] o;
    logic [IW-1:0] idx;
    pulse_clr;
    fill_and_stall;
    checks++;
    if (bus.O_VALID !== 1'b1) begin
      errors++;
      $display("FAIL arst_stalled: valid=%b required 1", bus.O_VALID);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.O_VALID !== 1'b0 || bus.O_BUSY !== 1'b0 || bus.O_READY !== 1'b0) begin
      errors++;
      $display("FAIL arst_flush: valid=%b busy=%b ready=%b required 0,0,0",
               bus.O_VALID, bus.O_BUSY, bus.O_READY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    one_row({COLS{16'h2000}}, 16'h2000, v1, v2, o, idx, last, sat);
    checks++;
    if (v2 !== 1'b1 || idx !== 4'd0 || o !== {COLS{16'h2000}}) begin
      errors++;
      $display("FAIL arst_restart: valid=%b idx=%0d row=%h required 1 idx 0 all 2000",
               v2, idx, o);
    end
  endtask

  initial begin
    bus.I_VALID = 1'b0;
    bus.I_ROW   = '0;
    bus.I_SCALE = '0;
    bus.I_READY = 1'b0;
    test_reset;
    test_unity;
    test_saturation;
    test_rounding;
    test_back_to_back;
    test_drain_block;
    test_clear;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
